riscv_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit for the pipelined core's EX stage.

---
 rtl/riscv_muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: multi-cycle RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with
// sign fix-up in a final cycle. Divide corner cases and unsupported op codes
// resolve in one cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one combinational
// 2*WIDTH multiplier and finish in one cycle; the divide path is unchanged.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an op; in_ready=1 unless flush
// MUL   | one shift-add step per cycle, counter runs WIDTH..1
// DIV   | one restore-subtract step per cycle, counter runs WIDTH..1
// FIX   | sign correction and hi/lo or quotient/remainder select
// DONE  | out_valid=1, result held until out_ready
module riscv_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(10);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(13);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic               neg_res, neg_rem;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               is_mul, is_div, a_signed, b_signed, neg_a, neg_b;
  logic               special;
  logic [WIDTH-1:0]   mag_a, mag_b, imm_result;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd, fix_result;

  // Operand classification and signedness of the incoming op.
  always_comb begin
    is_mul   = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    is_div   = (op == OP_REM) || (op == OP_REMU) || (op == OP_DIV) || (op == OP_DIVU);
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a    = a_signed & a[WIDTH-1];
    neg_b    = b_signed & b[WIDTH-1];
    mag_a    = neg_a ? (~a + 1'b1) : a;
    mag_b    = neg_b ? (~b + 1'b1) : b;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fa, fb;
  logic signed [2*WIDTH+1:0] fprod;
  logic [WIDTH-1:0]          fast_result;

  // Single-cycle signed/unsigned multiply via one sign-extended product.
  always_comb begin
    fa          = $signed({a_signed & a[WIDTH-1], a});
    fb          = $signed({b_signed & b[WIDTH-1], b});
    fprod       = fa * fb;
    fast_result = (op == OP_MUL) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
  end
`endif

  // Ops that finish without iterating, and their results.
  always_comb begin
    special    = 1'b0;
    imm_result = '0;
    if (is_div && (b == '0)) begin
      special    = 1'b1;
      imm_result = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_INT) && (b == '1)) begin
      special    = 1'b1;
      imm_result = (op == OP_DIV) ? MIN_INT : '0;
`ifdef MULDIV_FAST_MUL_EN
    end else if (is_mul) begin
      special    = 1'b1;
      imm_result = fast_result;
`endif
    end else if (!is_mul && !is_div) begin
      special    = 1'b1;
      imm_result = '0;
    end
  end

  // One iteration step of each algorithm plus the final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    prod      = {acc_hi, acc_lo};
    if (neg_res) prod = ~prod + 1'b1;
    quo       = neg_res ? (~acc_lo + 1'b1) : acc_lo;
    rmd       = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
    case (op_q)
      OP_MUL:                       fix_result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_result = quo;
      OP_REM, OP_REMU:              fix_result = rmd;
      default:                      fix_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic and handshake outputs; flush overrides everything but reset.
  always_comb begin
    state_d   = state;
    in_ready  = (state == S_IDLE) && !flush;
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    accept    = in_valid && in_ready;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (special)     state_d = S_DONE;
          else if (is_mul) state_d = S_MUL;
          else             state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt == CNT_W'(1)) state_d = S_FIX;
      S_FIX:        state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      op_q   <= op;
      cnt    <= CNT_W'(WIDTH);
      acc_hi <= '0;
      if (is_mul) begin
        acc_lo  <= mag_b;
        opnd    <= mag_a;
        neg_res <= neg_a ^ neg_b;
        neg_rem <= 1'b0;
      end else begin
        acc_lo  <= mag_a;
        opnd    <= mag_b;
        neg_res <= (op == OP_DIV) & (neg_a ^ neg_b);
        neg_rem <= (op == OP_REM) & neg_a;
      end
      if (special) result <= imm_result;
    end else begin
      case (state)
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          if (!div_diff[WIDTH+1]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: if (!flush) result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (WIDTH=32): scoreboard of expected
// results and latencies, one task per scenario.
module tb_riscv_muldiv_unit;

  localparam int W = 32;

  localparam logic [4:0] OP_MUL    = 5'd6;
  localparam logic [4:0] OP_MULH   = 5'd7;
  localparam logic [4:0] OP_MULHSU = 5'd8;
  localparam logic [4:0] OP_MULHU  = 5'd9;
  localparam logic [4:0] OP_REM    = 5'd10;
  localparam logic [4:0] OP_REMU   = 5'd11;
  localparam logic [4:0] OP_DIV    = 5'd12;
  localparam logic [4:0] OP_DIVU   = 5'd13;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]    op;
  logic [W-1:0]  a, b, result;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  int            lat_q[$];

  riscv_muldiv_unit #(.WIDTH(W), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference results from native 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint     sx, sy, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    p  = '0;
    model = '0;
    case (o)
      OP_MUL:    begin p = sx * sy; model = p[31:0];  end
      OP_MULH:   begin p = sx * sy; model = p[63:32]; end
      OP_MULHSU: begin p = sx * uy; model = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, x} * {32'd0, y}; model = p[63:32]; end
      OP_DIV: begin
        if (y == 0) model = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = x;
        else begin p = sx / sy; model = p[31:0]; end
      end
      OP_REM: begin
        if (y == 0) model = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = 32'd0;
        else begin p = sx % sy; model = p[31:0]; end
      end
      OP_DIVU: model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REMU: model = (y == 0) ? x : x % y;
      default: model = 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < OP_MUL || o > OP_DIVU) return 1;
    if (o <= OP_MULHU) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return W + 2;
`endif
    end
    if (y == 0) return 1;
    if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return W + 2;
  endfunction

  // Drive one op through the input handshake and record its expectation.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back(exp_lat(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
  endtask

  // Count cycles from the accept edge until out_valid; bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    n_tests++;
    if (result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", result);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mul();
    logic [4:0]  t_op[4] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    logic [31:0] t_a[4]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b[4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_e[4]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [4:0]  o;
    logic [31:0] x, y, e;
    int          lat, el;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        o = t_op[i]; x = t_a[i]; y = t_b[i]; e = t_e[i];
      end else begin
        o = OP_MUL + 5'($urandom_range(0, 3)); x = $urandom; y = $urandom; e = model(o, x, y);
      end
      issue(o, x, y, e);
      wait_result(lat);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (lat !== el) begin n_fail++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, el); end
      n_tests++;
      if (result !== e) begin n_fail++; $display("FAIL mul%0d_result: op=%0d got %h want %h", i, o, result, e); end
      complete();
    end
  endtask

  task automatic test_div();
    logic [4:0]  t_op[3] = '{OP_DIV, OP_REM, OP_DIVU};
    logic [31:0] t_a[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE};
    logic [31:0] t_b[3]  = '{32'd2, 32'd2, 32'd2};
    logic [31:0] t_e[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [4:0]  o;
    logic [31:0] x, y, e;
    int          lat, el;
    for (int i = 0; i < 11; i++) begin
      if (i < 3) begin
        o = t_op[i]; x = t_a[i]; y = t_b[i]; e = t_e[i];
      end else begin
        o = OP_REM + 5'($urandom_range(0, 3));
        x = $urandom;
        y = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
        if ((i % 4) == 0) y = -y;
        e = model(o, x, y);
      end
      issue(o, x, y, e);
      wait_result(lat);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (lat !== el) begin n_fail++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, el); end
      n_tests++;
      if (result !== e) begin n_fail++; $display("FAIL div%0d_result: op=%0d a=%h b=%h got %h want %h", i, o, x, y, result, e); end
      complete();
    end
  endtask

  task automatic test_special();
    logic [4:0]  t_op[8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, 5'd3, 5'd14};
    logic [31:0] t_a[8]  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] t_b[8]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd4};
    logic [31:0] t_e[8]  = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
    logic [31:0] e;
    int          lat, el;
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_e[i]);
      wait_result(lat);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++;
      if (lat !== el || lat !== 1) begin n_fail++; $display("FAIL special%0d_latency: got %0d want 1", i, lat); end
      n_tests++;
      if (result !== e) begin n_fail++; $display("FAIL special%0d_result: got %h want %h", i, result, e); end
      complete();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int          lat, el;
    logic        bad;
    issue(OP_DIV, 32'd100, 32'd7, 32'd14);
    wait_result(lat);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    n_tests++;
    if (lat !== el || result !== e) begin
      n_fail++; $display("FAIL b2b_first: lat=%0d result=%h want %0d %h", lat, result, el, e);
    end
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL stall_hold: out_valid=%b result=%h in_ready=%b want 1 0000000e 0", out_valid, result, in_ready);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    exp_q.push_back(32'd333); lat_q.push_back(exp_lat(OP_DIVU, 32'd1000, 32'd3));
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_idle: in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    wait_result(lat);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    n_tests++;
    if (lat !== el) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, el); end
    n_tests++;
    if (result !== e) begin n_fail++; $display("FAIL b2b_result: got %h want %h", result, e); end
    complete();
  endtask

  task automatic test_flush();
    logic [31:0] e;
    int          lat, el;
    logic        bad;
    issue(OP_DIV, 32'd1234, 32'd5, 32'd246);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd3;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_mid_pre: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_mid: busy=%b out_valid=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready);
    end
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL flush_stale: out_valid=%b busy=%b want 0 0", out_valid, busy); end
    exp_q.delete(); lat_q.delete();

    issue(OP_MUL, 32'd3, 32'd5, 32'd15);
    wait_result(lat);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    n_tests++;
    if (lat !== el || result !== e) begin
      n_fail++; $display("FAIL flush_done_pre: lat=%0d result=%h want %0d %h", lat, result, el, e);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd15) begin
      n_fail++; $display("FAIL flush_done: out_valid=%b busy=%b result=%h want 0 0 0000000f", out_valid, busy, result);
    end

    issue(OP_REMU, 32'd17, 32'd5, 32'd2);
    wait_result(lat);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    n_tests++;
    if (lat !== el || result !== e) begin
      n_fail++; $display("FAIL flush_recover: lat=%0d result=%h want %0d %h", lat, result, el, e);
    end
    complete();
  endtask

  task automatic test_rst_mid();
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%b busy=%b in_ready=%b result=%h want 0 0 1 0", out_valid, busy, in_ready, result);
    end
    exp_q.delete(); lat_q.delete();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
